// File: rtl/feature_region_sequencer_pkg.sv
// Shared types for the feature region sequencer: region bounds, scan states
// and the inclusive window test used by the pixel counter.
package feature_scan_pkg;

  localparam int POS_W = 12;

  typedef logic [POS_W-1:0] pos_t;

  typedef struct packed {
    pos_t left;
    pos_t right;
    pos_t up;
    pos_t down;
  } region_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    COUNT
  } scan_state_e;

  // Inverted bounds (left>right or up>down) can never match, giving an empty window.
  function automatic logic in_window(region_t w, pos_t x, pos_t y);
    return (x >= w.left) && (x <= w.right) && (y >= w.up) && (y <= w.down);
  endfunction

endpackage

// File: rtl/feature_region_sequencer_if.sv
// Pixel stream, region-table config, scan control and result bundle for
// the feature region sequencer.
interface feature_region_sequencer_if #(
  parameter int NUM_REGIONS = 7,
  parameter int IDX_W       = 3,
  parameter int CNT_W       = 24
);
  import feature_scan_pkg::*;

  logic                   i_vs;
  logic                   i_de;
  pos_t                   i_x;
  pos_t                   i_y;
  logic                   i_th;
  logic                   cfg_we;
  logic [IDX_W-1:0]       cfg_addr;
  pos_t                   cfg_left;
  pos_t                   cfg_right;
  pos_t                   cfg_up;
  pos_t                   cfg_down;
  logic                   start;
  logic                   continuous;
  logic                   busy;
  logic [IDX_W-1:0]       region_idx;
  logic                   count_valid;
  logic [CNT_W-1:0]       region_count;
  logic                   result_valid;
  logic [NUM_REGIONS-1:0] seg_bits;

  modport master (
    output i_vs, i_de, i_x, i_y, i_th,
    output cfg_we, cfg_addr, cfg_left, cfg_right, cfg_up, cfg_down,
    output start, continuous,
    input  busy, region_idx, count_valid, region_count, result_valid, seg_bits
  );

  modport slave (
    input  i_vs, i_de, i_x, i_y, i_th,
    input  cfg_we, cfg_addr, cfg_left, cfg_right, cfg_up, cfg_down,
    input  start, continuous,
    output busy, region_idx, count_valid, region_count, result_valid, seg_bits
  );

endinterface

// File: rtl/feature_region_sequencer_window_counter.sv
// Saturating count of feature pixels inside a snapshotted rectangular window.
module region_window_counter
  import feature_scan_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  region_t          win,
  input  logic             vs,
  input  logic             de,
  input  logic             th,
  input  pos_t             x,
  input  pos_t             y,
  output logic [CNT_W-1:0] acc
);

  logic hit_pixel;

  assign hit_pixel = enable && vs && de && th && in_window(win, x, y);

  // Clear wins over counting so a pixel on the SOF edge never leaks into the new region.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (hit_pixel && (acc != '1)) begin
      acc <= acc + CNT_W'(1);
    end
  end

endmodule

// File: rtl/feature_region_sequencer.sv
// Scans one region per frame through a shared window counter and publishes
// a one-bit-per-region feature vector after the last region.
module feature_region_sequencer
  import feature_scan_pkg::*;
#(
  parameter int NUM_REGIONS = 7,
  parameter int IDX_W       = 3,
  parameter int CNT_W       = 24,
  parameter int MIN_COUNT   = 500
) (
  input logic                        clk,
  input logic                        rst_n,
  feature_region_sequencer_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGIONS - 1);
  localparam logic [31:0]      MIN_TH   = 32'(MIN_COUNT);

  scan_state_e            state;
  logic                   vs_d;
  logic                   sof;
  logic                   eof;
  region_t                region_tab [NUM_REGIONS];
  region_t                win;
  logic [CNT_W-1:0]       acc;
  logic                   acc_clear;
  logic                   acc_en;
  logic                   hit;
  logic [NUM_REGIONS-1:0] work_vec;
  logic [NUM_REGIONS-1:0] final_vec;

  logic                   busy_r;
  logic [IDX_W-1:0]       idx_r;
  logic                   cnt_valid_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   res_valid_r;
  logic [NUM_REGIONS-1:0] seg_r;

  assign sof       = bus.i_vs & ~vs_d;
  assign eof       = ~bus.i_vs & vs_d;
  assign acc_clear = (state == WAIT_SOF) && sof;
  assign acc_en    = (state == COUNT);
  assign hit       = 32'(acc) >= MIN_TH;

  always_comb begin
    final_vec        = work_vec;
    final_vec[idx_r] = hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_d <= 1'b0;
    end else begin
      vs_d <= bus.i_vs;
    end
  end

  // Out-of-range addresses are dropped so a narrow table never aliases.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        region_tab[i] <= '0;
      end
    end else if (bus.cfg_we && (32'(bus.cfg_addr) < 32'(NUM_REGIONS))) begin
      region_tab[bus.cfg_addr] <= '{left:  bus.cfg_left,  right: bus.cfg_right,
                                    up:    bus.cfg_up,    down:  bus.cfg_down};
    end
  end

  region_window_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (acc_clear),
    .enable (acc_en),
    .win    (win),
    .vs     (bus.i_vs),
    .de     (bus.i_de),
    .th     (bus.i_th),
    .x      (bus.i_x),
    .y      (bus.i_y),
    .acc    (acc)
  );

  // Bounds are snapshotted at SOF so mid-frame table writes only affect the next visit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy_r      <= 1'b0;
      idx_r       <= '0;
      cnt_valid_r <= 1'b0;
      cnt_r       <= '0;
      res_valid_r <= 1'b0;
      seg_r       <= '0;
      work_vec    <= '0;
      win         <= '0;
    end else begin
      cnt_valid_r <= 1'b0;
      res_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_r   <= 1'b1;
            idx_r    <= '0;
            work_vec <= '0;
            state    <= WAIT_SOF;
          end
        end
        WAIT_SOF: begin
          if (sof) begin
            win   <= region_tab[idx_r];
            state <= COUNT;
          end
        end
        COUNT: begin
          if (eof) begin
            cnt_r       <= acc;
            cnt_valid_r <= 1'b1;
            work_vec    <= final_vec;
            if (idx_r != LAST_IDX) begin
              idx_r <= idx_r + IDX_W'(1);
              state <= WAIT_SOF;
            end else begin
              seg_r       <= final_vec;
              res_valid_r <= 1'b1;
              idx_r       <= '0;
              if (bus.continuous) begin
                work_vec <= '0;
                state    <= WAIT_SOF;
              end else begin
                busy_r <= 1'b0;
                state  <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_r;
  assign bus.region_idx   = idx_r;
  assign bus.count_valid  = cnt_valid_r;
  assign bus.region_count = cnt_r;
  assign bus.result_valid = res_valid_r;
  assign bus.seg_bits     = seg_r;

endmodule

// File: tb/tb_feature_region_sequencer.sv
// Directed scoreboard bench for feature_region_sequencer: single and continuous
// scans, threshold edges, mid-frame start, mid-frame config, reset and saturation.
module tb_feature_region_sequencer;
  import feature_scan_pkg::*;

  localparam int NR = 7;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  feature_region_sequencer_if #(.NUM_REGIONS(NR), .IDX_W(3), .CNT_W(24)) bus ();
  feature_region_sequencer_if #(.NUM_REGIONS(1),  .IDX_W(1), .CNT_W(8))  sat_bus ();

  feature_region_sequencer #(
    .NUM_REGIONS (NR),
    .IDX_W       (3),
    .CNT_W       (24),
    .MIN_COUNT   (500)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  feature_region_sequencer #(
    .NUM_REGIONS (1),
    .IDX_W       (1),
    .CNT_W       (8),
    .MIN_COUNT   (200)
  ) sat_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sat_bus)
  );

  assign sat_bus.i_vs = bus.i_vs;
  assign sat_bus.i_de = bus.i_de;
  assign sat_bus.i_x  = bus.i_x;
  assign sat_bus.i_y  = bus.i_y;
  assign sat_bus.i_th = bus.i_th;

  typedef struct {
    int cnt;
    int idx;
  } exp_t;

  exp_t           cv_q[$];
  logic [NR-1:0]  sb_q[$];
  logic [NR-1:0]  exp_vec;
  region_t        tb_tab [NR];
  region_t        scan_rect [NR];
  int vectors       = 0;
  int miscompares   = 0;
  int frame_no      = 0;
  int last_rv_frame = -1;
  int rv_count      = 0;
  int sat_seen      = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic region_t mk(int l, int r, int u, int d);
    mk = '{left: pos_t'(l), right: pos_t'(r), up: pos_t'(u), down: pos_t'(d)};
  endfunction

  // Reference count: area of the window clipped to the driven pixel rectangle.
  function automatic int expCount(region_t w, region_t r);
    int lx, hx, ly, hy;
    if (w.left > w.right || w.up > w.down) return 0;
    lx = (w.left  > r.left)  ? int'(w.left)  : int'(r.left);
    hx = (w.right < r.right) ? int'(w.right) : int'(r.right);
    ly = (w.up    > r.up)    ? int'(w.up)    : int'(r.up);
    hy = (w.down  < r.down)  ? int'(w.down)  : int'(r.down);
    if (lx > hx || ly > hy) return 0;
    return (hx - lx + 1) * (hy - ly + 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfgWrite(input int k, input region_t b);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 3'(k);
    bus.cfg_left  = b.left;
    bus.cfg_right = b.right;
    bus.cfg_up    = b.up;
    bus.cfg_down  = b.down;
    step();
    bus.cfg_we    = 1'b0;
    tb_tab[k]     = b;
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic drivePixels(input region_t r);
    for (int y = int'(r.up); y <= int'(r.down); y++) begin
      for (int x = int'(r.left); x <= int'(r.right); x++) begin
        bus.i_de = 1'b1;
        bus.i_th = 1'b1;
        bus.i_x  = pos_t'(x);
        bus.i_y  = pos_t'(y);
        step();
      end
    end
  endtask

  task automatic frameTail();
    bus.i_de = 1'b0;
    step();
    step();
    bus.i_vs = 1'b0;
    repeat (4) step();
  endtask

  // One full frame; when counted, the expected count/index/vector go to the scoreboard first.
  task automatic applyStimulus(input int k, input bit counted, input region_t rect,
                               input bit mid_cfg, input region_t newb);
    exp_t e;
    if (counted) begin
      e.cnt = expCount(tb_tab[k], rect);
      e.idx = (k == NR - 1) ? 0 : k + 1;
      cv_q.push_back(e);
      exp_vec[k] = (e.cnt >= 500);
      if (k == NR - 1) begin
        sb_q.push_back(exp_vec);
        exp_vec = '0;
      end
    end
    frame_no++;
    step();
    bus.i_vs = 1'b1;
    step();
    step();
    if (mid_cfg) cfgWrite(k, newb);
    drivePixels(rect);
    frameTail();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.count_valid === 1'b1) begin
      if (cv_q.size() == 0) begin
        checkOutput("unexpected_count_valid", 32'(bus.count_valid), 32'd0);
      end else begin
        e = cv_q.pop_front();
        checkOutput("region_count", 32'(bus.region_count), e.cnt);
        checkOutput("region_idx_next", 32'(bus.region_idx), e.idx);
      end
    end
    if (bus.result_valid === 1'b1) begin
      rv_count++;
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_result_valid", 32'(bus.result_valid), 32'd0);
      end else begin
        checkOutput("seg_bits", 32'(bus.seg_bits), 32'(sb_q.pop_front()));
      end
      if (last_rv_frame >= 0) checkOutput("result_gap_frames", frame_no - last_rv_frame, 7);
      last_rv_frame = frame_no;
    end
    if (sat_bus.count_valid === 1'b1) begin
      sat_seen++;
      checkOutput("sat_region_count", 32'(sat_bus.region_count), 32'd255);
    end
  end

  initial begin
    rst_n              = 1'b0;
    bus.i_vs           = 1'b0;
    bus.i_de           = 1'b0;
    bus.i_th           = 1'b0;
    bus.i_x            = '0;
    bus.i_y            = '0;
    bus.cfg_we         = 1'b0;
    bus.cfg_addr       = '0;
    bus.cfg_left       = '0;
    bus.cfg_right      = '0;
    bus.cfg_up         = '0;
    bus.cfg_down       = '0;
    bus.start          = 1'b0;
    bus.continuous     = 1'b0;
    sat_bus.cfg_we     = 1'b0;
    sat_bus.cfg_addr   = '0;
    sat_bus.cfg_left   = '0;
    sat_bus.cfg_right  = '0;
    sat_bus.cfg_up     = '0;
    sat_bus.cfg_down   = '0;
    sat_bus.start      = 1'b0;
    sat_bus.continuous = 1'b0;
    exp_vec            = '0;
    for (int i = 0; i < NR; i++) tb_tab[i] = '0;

    repeat (3) step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    checkOutput("reset_busy",         32'(bus.busy),         32'd0);
    checkOutput("reset_region_idx",   32'(bus.region_idx),   32'd0);
    checkOutput("reset_count_valid",  32'(bus.count_valid),  32'd0);
    checkOutput("reset_result_valid", 32'(bus.result_valid), 32'd0);
    checkOutput("reset_region_count", 32'(bus.region_count), 32'd0);
    checkOutput("reset_seg_bits",     32'(bus.seg_bits),     32'd0);

    // Saturation: 1000 feature pixels into an 8-bit accumulator; main block stays idle.
    step();
    sat_bus.cfg_left  = 12'd0;
    sat_bus.cfg_right = 12'd39;
    sat_bus.cfg_up    = 12'd0;
    sat_bus.cfg_down  = 12'd24;
    sat_bus.cfg_we    = 1'b1;
    step();
    sat_bus.cfg_we    = 1'b0;
    sat_bus.start     = 1'b1;
    step();
    sat_bus.start     = 1'b0;
    applyStimulus(0, 1'b0, mk(0, 39, 0, 24), 1'b0, mk(0, 0, 0, 0));
    checkOutput("sat_count_valid_seen", sat_seen, 1);
    checkOutput("sat_seg_bit",          32'(sat_bus.seg_bits), 32'd1);
    checkOutput("sat_busy_done",        32'(sat_bus.busy),     32'd0);
    checkOutput("main_idle_no_result",  rv_count, 0);

    // Single scan: big window, 500 / 499 threshold edges, inverted window, small windows.
    cfgWrite(0, mk(70, 140, 80, 190));
    cfgWrite(1, mk(0, 24, 0, 19));
    cfgWrite(2, mk(0, 498, 0, 0));
    cfgWrite(3, mk(200, 100, 0, 10));
    for (int k = 4; k < NR; k++) cfgWrite(k, mk(0, 9, 0, 9));
    scan_rect[0] = mk(69, 141, 79, 191);
    scan_rect[1] = mk(0, 30, 0, 21);
    scan_rect[2] = mk(0, 500, 0, 1);
    scan_rect[3] = mk(95, 205, 0, 1);
    for (int k = 4; k < NR; k++) scan_rect[k] = mk(0, 11, 0, 11);

    bus.continuous = 1'b0;
    last_rv_frame  = -1;
    pulseStart();
    checkOutput("busy_after_start", 32'(bus.busy),       32'd1);
    checkOutput("idx_after_start",  32'(bus.region_idx), 32'd0);
    for (int k = 0; k < NR; k++) applyStimulus(k, 1'b1, scan_rect[k], 1'b0, mk(0, 0, 0, 0));
    step();
    checkOutput("single_busy_done",    32'(bus.busy),     32'd0);
    checkOutput("single_result_count", rv_count,          1);
    checkOutput("single_seg_hold",     32'(bus.seg_bits), 32'd3);

    // Continuous: two back-to-back scans, mid-frame rewrite of region 0, continuous dropped in scan 2.
    cfgWrite(0, mk(0, 9, 0, 9));
    scan_rect[0]   = mk(0, 11, 0, 11);
    bus.continuous = 1'b1;
    last_rv_frame  = -1;
    pulseStart();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < NR; k++) begin
        applyStimulus(k, 1'b1, scan_rect[k], (s == 0 && k == 0), mk(2, 9, 0, 9));
        if (s == 1 && k == 2) bus.continuous = 1'b0;
        if (s == 0 && k == NR - 1) begin
          checkOutput("cont_busy_rearm", 32'(bus.busy),       32'd1);
          checkOutput("cont_idx_wrap",   32'(bus.region_idx), 32'd0);
        end
      end
    end
    step();
    checkOutput("cont_busy_done",    32'(bus.busy), 32'd0);
    checkOutput("cont_result_count", rv_count,      3);

    // Start accepted mid-frame: that frame's EOF must not produce a count.
    step();
    bus.i_vs = 1'b1;
    step();
    step();
    drivePixels(mk(0, 11, 0, 5));
    pulseStart();
    drivePixels(mk(0, 11, 6, 11));
    frameTail();
    checkOutput("midstart_busy", 32'(bus.busy), 32'd1);
    applyStimulus(0, 1'b1, mk(0, 11, 0, 11), 1'b0, mk(0, 0, 0, 0));

    // Reset in the middle of counting region 1.
    step();
    bus.i_vs = 1'b1;
    step();
    step();
    drivePixels(mk(0, 11, 0, 3));
    bus.i_de = 1'b0;
    rst_n    = 1'b0;
    step();
    @(negedge clk);
    checkOutput("midrst_busy",         32'(bus.busy),         32'd0);
    checkOutput("midrst_region_idx",   32'(bus.region_idx),   32'd0);
    checkOutput("midrst_count_valid",  32'(bus.count_valid),  32'd0);
    checkOutput("midrst_result_valid", 32'(bus.result_valid), 32'd0);
    checkOutput("midrst_region_count", 32'(bus.region_count), 32'd0);
    checkOutput("midrst_seg_bits",     32'(bus.seg_bits),     32'd0);
    step();
    bus.i_vs = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) tb_tab[i] = '0;
    repeat (4) step();
    checkOutput("post_reset_busy", 32'(bus.busy), 32'd0);

    checkOutput("pending_count_valid", cv_q.size(), 0);
    checkOutput("pending_seg_bits",    sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
